// File: rtl/hash_target_checker_if.sv
// hash_target_checker_if
// Bundles the control handshake and the shared-memory bus of the hash target
// checker.
//   master : the checker itself (drives the memory bus and the result outputs)
//   slave  : the environment (controller plus synchronous word memory)
// Signals:
//   start                     scan request, sampled in IDLE/DONE
//   hash_addr/target_addr/result_addr  16-bit word base addresses
//   done/found/nonce_out      result outputs
//   mem_clk/mem_we/mem_addr/mem_write_data  memory request side
//   mem_read_data             memory data, valid the cycle after the address
interface hash_target_checker_if;
  logic        start;
  logic [15:0] hash_addr;
  logic [15:0] target_addr;
  logic [15:0] result_addr;
  logic        done;
  logic        found;
  logic [31:0] nonce_out;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    input  start, hash_addr, target_addr, result_addr, mem_read_data,
    output done, found, nonce_out, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    output start, hash_addr, target_addr, result_addr, mem_read_data,
    input  done, found, nonce_out, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/hash_target_checker.sv
// hash_target_checker
// Reads a 256-bit target and NUM_NONCES 8-word digests from shared memory,
// compares each digest (word 0 most significant) against the target as an
// unsigned number and writes a 2-word record {found, nonce} to result_addr.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    hash_target_checker_if.master (control, result and memory bus)
// Build option:
//   BEST_HASH_EN  scan all nonces and report the smallest qualifying digest
//                 (lower nonce on ties); otherwise stop at the first hit.
//
// state   | meaning
// IDLE    | waiting for start
// RD_TGT  | reading the 8 target words (k = 0..8)
// RD_HASH | reading the 8 words of digest n (k = 0..8)
// CMP     | compare digest n, update hit, choose next nonce or write-back
// WR_RES0 | writing {31'b0, found} to result_addr
// WR_RES1 | writing nonce to result_addr + 1
// DONE    | result valid, waiting for start
module hash_target_checker #(
  parameter int NUM_NONCES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hash_target_checker_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_TGT, RD_HASH, CMP, WR_RES0, WR_RES1, DONE
  } state_t;

  localparam logic [15:0] LAST_N = 16'(NUM_NONCES - 1);

  state_t           state;
  logic [3:0]       k;
  logic [15:0]      n;
  logic [7:0][31:0] tgt_q;   // index 7 holds word 0 (MSW)
  logic [7:0][31:0] dig_q;
  logic [2:0]       widx;
  logic [15:0]      hash_base;
  logic             hit;
  logic             res_found;
  logic [15:0]      res_nonce;
  logic             last_cmp;

  assign bus.mem_clk = clk;

  // Word k-1 arrives while k is presented; word 0 lands in the top slot.
  assign widx      = 3'(4'd8 - k);
  assign hash_base = bus.hash_addr + {n[12:0], 3'b000};
  assign hit       = dig_q < tgt_q;

`ifdef BEST_HASH_EN
  logic [255:0] best_q;
  logic         best_vld;
  logic [15:0]  best_n;
  logic         take;

  // Strictly smaller only, so an equal later digest keeps the earlier nonce.
  assign take      = hit && (!best_vld || (dig_q < best_q));
  assign res_found = best_vld | hit;
  assign res_nonce = take ? n : best_n;
  assign last_cmp  = (n == LAST_N);
`else
  assign res_found = hit;
  assign res_nonce = n;
  assign last_cmp  = hit || (n == LAST_N);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      k                  <= '0;
      n                  <= '0;
      tgt_q              <= '0;
      dig_q              <= '0;
      bus.done           <= 1'b0;
      bus.found          <= 1'b0;
      bus.nonce_out      <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
`ifdef BEST_HASH_EN
      best_q             <= '0;
      best_vld           <= 1'b0;
      best_n             <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= RD_TGT;
            k             <= '0;
            n             <= '0;
            bus.done      <= 1'b0;
            bus.found     <= 1'b0;
            bus.nonce_out <= '0;
            bus.mem_addr  <= bus.target_addr;
`ifdef BEST_HASH_EN
            best_vld      <= 1'b0;
`endif
          end
        end
        RD_TGT: begin
          if (k != 4'd0) tgt_q[widx] <= bus.mem_read_data;
          if (k < 4'd7) bus.mem_addr <= bus.target_addr + 16'(k) + 16'd1;
          if (k == 4'd8) begin
            state        <= RD_HASH;
            k            <= '0;
            bus.mem_addr <= hash_base;
          end else begin
            k <= k + 4'd1;
          end
        end
        RD_HASH: begin
          if (k != 4'd0) dig_q[widx] <= bus.mem_read_data;
          if (k < 4'd7) bus.mem_addr <= hash_base + 16'(k) + 16'd1;
          if (k == 4'd8) begin
            state <= CMP;
            k     <= '0;
          end else begin
            k <= k + 4'd1;
          end
        end
        CMP: begin
`ifdef BEST_HASH_EN
          if (take) begin
            best_q   <= dig_q;
            best_n   <= n;
            best_vld <= 1'b1;
          end
`endif
          if (last_cmp) begin
            state              <= WR_RES0;
            bus.mem_we         <= 1'b1;
            bus.mem_addr       <= bus.result_addr;
            bus.mem_write_data <= {31'b0, res_found};
            bus.found          <= res_found;
            bus.nonce_out      <= res_found ? {16'b0, res_nonce} : 32'hFFFF_FFFF;
          end else begin
            state        <= RD_HASH;
            n            <= n + 16'd1;
            bus.mem_addr <= hash_base + 16'd8;
          end
        end
        WR_RES0: begin
          state              <= WR_RES1;
          bus.mem_addr       <= bus.result_addr + 16'd1;
          bus.mem_write_data <= bus.nonce_out;
        end
        WR_RES1: begin
          state      <= DONE;
          bus.mem_we <= 1'b0;
          bus.done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_target_checker.sv
module tb_hash_target_checker;
  logic clk = 1'b0;
  logic reset;

  hash_target_checker_if bus();

  hash_target_checker #(.NUM_NONCES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge bus.mem_clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
    bus.mem_read_data <= mem[bus.mem_addr];
  end

  localparam logic [15:0] TGT  = 16'h0100;
  localparam logic [15:0] RES  = 16'h0200;
  localparam logic [15:0] HASH = 16'h1000;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
`ifdef BEST_HASH_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  localparam logic [255:0] ONES = '1;
  localparam logic [255:0] T_NOHIT = {{7{32'hFFFF_FFFF}}, 32'hFFFF_FFFE};
  localparam logic [255:0] T1      = {32'h0000_1000, 224'b0};
  localparam logic [255:0] D_FFF   = {32'h0000_0FFF, 224'b0};
  localparam logic [255:0] D_800   = {32'h0000_0800, 224'b0};
  localparam logic [255:0] T2      = {32'h0000_1000, 192'b0, 32'h0000_0010};
  localparam logic [255:0] T2_M1   = {32'h0000_1000, 192'b0, 32'h0000_000F};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic put256(input logic [15:0] addr, input logic [255:0] v);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = addr + 16'(i);
      mem[a] = v[255-32*i -: 32];
    end
  endtask

  task automatic prep(input logic [15:0] base, input logic [255:0] tgt);
    for (int d = 0; d < 16; d++) put256(base + 16'(8*d), ONES);
    put256(TGT, tgt);
    mem[RES]       = SENT;
    mem[RES + 1]   = SENT;
    bus.hash_addr  = base;
  endtask

  task automatic launch();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_scan(input string tag, input bit exp_found, input logic [31:0] exp_nonce,
                          input int exp_lat, input int pulse_at, input bit hold);
    int cyc;
    int wr;
    cyc = 0;
    wr  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 if (!hold) bus.start = 1'b0;
    while (cyc < 400) begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.mem_we) wr++;
      if (bus.done) break;
      if (!hold && cyc == pulse_at) bus.start = 1'b1;
      else if (!hold && cyc == pulse_at + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " found"}, {31'b0, bus.found}, {31'b0, exp_found});
    check({tag, " nonce_out"}, bus.nonce_out, exp_nonce);
    check({tag, " mem_res0"}, mem[RES], {31'b0, exp_found});
    check({tag, " mem_res1"}, mem[RES + 1], exp_nonce);
    check({tag, " write_cycles"}, 32'(wr), 32'd2);
  endtask

  initial begin
    int cnt;
    bit seen;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.hash_addr   = HASH;
    bus.target_addr = TGT;
    bus.result_addr = RES;
    #12;
    @(negedge clk) reset = 1'b0;
    #1;
    check("rst done", {31'b0, bus.done}, 32'd0);
    check("rst found", {31'b0, bus.found}, 32'd0);
    check("rst nonce_out", bus.nonce_out, 32'd0);
    check("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    check("rst mem_wdata", bus.mem_write_data, 32'd0);

    prep(HASH, T_NOHIT);
    run_scan("nohit", 1'b0, 32'hFFFF_FFFF, 171, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("done_hold", {31'b0, bus.done}, 32'd1);

    prep(HASH, T1);
    put256(HASH + 16'd40, D_FFF);
    run_scan("hit5", 1'b1, 32'd5, BEST ? 171 : 71, 0, 1'b0);

    prep(HASH, T1);
    put256(HASH + 16'd24, D_FFF);
    put256(HASH + 16'd72, D_800);
    run_scan("two_hits", 1'b1, BEST ? 32'd9 : 32'd3, BEST ? 171 : 51, 0, 1'b0);

    prep(HASH, T1);
    put256(HASH + 16'd24, D_FFF);
    put256(HASH + 16'd72, D_FFF);
    run_scan("tie", 1'b1, 32'd3, BEST ? 171 : 51, 0, 1'b0);

    prep(HASH, T2);
    put256(HASH + 16'd16, T2);
    put256(HASH + 16'd32, T2_M1);
    run_scan("equal_vs_less", 1'b1, 32'd4, BEST ? 171 : 61, 0, 1'b0);

    prep(16'hFFF8, T1);
    put256(16'h0000, D_FFF);
    run_scan("wrap", 1'b1, 32'd1, BEST ? 171 : 31, 0, 1'b0);

    prep(HASH, T1);
    put256(HASH + 16'd40, D_FFF);
    run_scan("pulse_ignored", 1'b1, 32'd5, BEST ? 171 : 71, 15, 1'b0);

    prep(HASH, T1);
    put256(HASH + 16'd40, D_FFF);
    run_scan("held_restart", 1'b1, 32'd5, BEST ? 171 : 71, 0, 1'b1);

    prep(HASH, T_NOHIT);
    launch();
    repeat (39) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst40 done", {31'b0, bus.done}, 32'd0);
    check("rst40 mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst40 mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    @(negedge clk) reset = 1'b0;

    prep(HASH, T_NOHIT);
    launch();
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 400 && !seen) begin
      @(posedge clk);
      cnt++;
      #1 seen = bus.mem_we;
    end
    check("wr_reached", {31'b0, seen}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_wr mem_we", {31'b0, bus.mem_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr res0_kept", mem[RES], SENT);
    check("rst_wr res1_kept", mem[RES + 1], SENT);
    @(negedge clk) reset = 1'b0;

    prep(HASH, T1);
    put256(HASH + 16'd40, D_FFF);
    run_scan("after_reset", 1'b1, 32'd5, BEST ? 171 : 71, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_done done", {31'b0, bus.done}, 32'd0);
    check("rst_done found", {31'b0, bus.found}, 32'd0);
    check("rst_done nonce_out", bus.nonce_out, 32'd0);
    @(negedge clk) reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
